mult_iter: RTL

- Parametrised iterative multiplier for the EX stage. Successor to the fixed-latency 32x32 multiplier wrapper.
- Handles the signed/unsigned multiply and the multiply-accumulate/subtract group: MULT, MULTU, MADD, MADDU, MSUB, MSUBU.
- Latency is set by how many multiplier bits are retired per cycle. It uses the same start/ready/flush handshake as the current multiplier, plus a busy indication.

---
 rtl/mult_iter_if.sv | 40 ++++
 rtl/mult_iter.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/mult_iter_if.sv
// Handshake and operand bundle for the iterative multiplier.
// The master side issues operations and the slave side (the multiplier)
// returns the result together with the ready and busy indications.
interface mult_iter_if #(
    parameter int WIDTH = 32
);
    logic                 start_i;
    logic                 flush;
    logic [2:0]           op_i;
    logic [WIDTH-1:0]     mcand_i;
    logic [WIDTH-1:0]     mplier_i;
    logic [2*WIDTH-1:0]   hilo_i;
    logic [2*WIDTH-1:0]   result_o;
    logic                 ready_o;
    logic                 busy_o;

    modport master (
        output start_i,
        output flush,
        output op_i,
        output mcand_i,
        output mplier_i,
        output hilo_i,
        input  result_o,
        input  ready_o,
        input  busy_o
    );

    modport slave (
        input  start_i,
        input  flush,
        input  op_i,
        input  mcand_i,
        input  mplier_i,
        input  hilo_i,
        output result_o,
        output ready_o,
        output busy_o
    );
endinterface

// File: rtl/mult_iter.sv
// Iterative multiplier for the EX stage.
// Handles MULT/MULTU/MADD/MADDU/MSUB/MSUBU. Operands are converted to
// magnitudes on acceptance, BPC multiplier bits are retired per cycle, and
// the sign fix-up plus accumulate/subtract happen in a single ADJ cycle.
// op_i encoding: bit0 = signed; bits[2:1] = 00 mul, 01 madd, 10 msub,
// 11 reserved (behaves as mul).
module mult_iter #(
    parameter int WIDTH = 32,
    parameter int BPC   = 8
) (
    input  logic           clk,
    input  logic           rst,
    mult_iter_if.slave     bus
);

    // Number of CALC iterations and the counter that tracks them.
    localparam int N  = WIDTH / BPC;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

    // A multiplier width that is not a whole number of slices is unusable.
    if ((WIDTH % BPC) != 0) begin : g_bad_bpc
        $error("mult_iter: WIDTH must be a multiple of BPC");
    end

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_ADJ  = 2'b10,
        ST_DONE = 2'b11
    } state_t;

    // Magnitude of an operand; only negated when treated as signed.
    // The most negative value maps onto 2^(WIDTH-1), which still fits.
    function automatic logic [WIDTH-1:0] magnitude(
        input logic [WIDTH-1:0] value,
        input logic             is_signed
    );
        logic [WIDTH-1:0] mag;
        if (is_signed && value[WIDTH-1]) begin
            mag = {WIDTH{1'b0}} - value;
        end else begin
            mag = value;
        end
        return mag;
    endfunction

    state_t               state_r;
    logic [CW-1:0]        cnt_r;
    logic [2:0]           op_r;
    logic                 neg_r;
    logic [2*WIDTH-1:0]   hilo_r;
    logic [2*WIDTH-1:0]   mcand_sh_r;
    logic [WIDTH-1:0]     mplier_sh_r;
    logic [2*WIDTH-1:0]   acc_r;
    logic [2*WIDTH-1:0]   result_r;
    logic                 ready_r;
    logic                 busy_r;

    logic [WIDTH-1:0]     mcand_abs_s;
    logic [WIDTH-1:0]     mplier_abs_s;
    logic                 neg_s;
    logic                 accept_s;
    logic [2*WIDTH-1:0]   partial_s;
    logic [2*WIDTH-1:0]   prod_s;
    logic [2*WIDTH-1:0]   adj_s;

    // Operand conditioning for a new operation: magnitudes and result sign.
    always_comb begin
        mcand_abs_s  = magnitude(bus.mcand_i, bus.op_i[0]);
        mplier_abs_s = magnitude(bus.mplier_i, bus.op_i[0]);
        if (bus.op_i[0]) begin
            neg_s = bus.mcand_i[WIDTH-1] ^ bus.mplier_i[WIDTH-1];
        end else begin
            neg_s = 1'b0;
        end
    end

    // A start is taken only in IDLE or DONE, and never alongside a flush.
    always_comb begin
        if (!bus.flush && bus.start_i &&
            ((state_r == ST_IDLE) || (state_r == ST_DONE))) begin
            accept_s = 1'b1;
        end else begin
            accept_s = 1'b0;
        end
    end

    // Partial product of the pre-shifted multiplicand and the current slice.
    always_comb begin
        partial_s = mcand_sh_r * {{(2*WIDTH-BPC){1'b0}}, mplier_sh_r[BPC-1:0]};
    end

    // Sign fix-up followed by the accumulate/subtract selected by the op.
    always_comb begin
        if (neg_r) begin
            prod_s = {(2*WIDTH){1'b0}} - acc_r;
        end else begin
            prod_s = acc_r;
        end
        case (op_r[2:1])
            2'b01:   adj_s = hilo_r + prod_s;
            2'b10:   adj_s = hilo_r - prod_s;
            2'b00:   adj_s = prod_s;
            default: adj_s = prod_s;
        endcase
    end

    // Control FSM, datapath registers and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            cnt_r       <= {CW{1'b0}};
            op_r        <= 3'b000;
            neg_r       <= 1'b0;
            hilo_r      <= {(2*WIDTH){1'b0}};
            mcand_sh_r  <= {(2*WIDTH){1'b0}};
            mplier_sh_r <= {WIDTH{1'b0}};
            acc_r       <= {(2*WIDTH){1'b0}};
            result_r    <= {(2*WIDTH){1'b0}};
            ready_r     <= 1'b0;
            busy_r      <= 1'b0;
        end else if (bus.flush) begin
            state_r <= ST_IDLE;
            ready_r <= 1'b0;
            busy_r  <= 1'b0;
        end else if (accept_s) begin
            state_r     <= ST_CALC;
            cnt_r       <= {CW{1'b0}};
            op_r        <= bus.op_i;
            neg_r       <= neg_s;
            hilo_r      <= bus.hilo_i;
            mcand_sh_r  <= {{WIDTH{1'b0}}, mcand_abs_s};
            mplier_sh_r <= mplier_abs_s;
            acc_r       <= {(2*WIDTH){1'b0}};
            ready_r     <= 1'b0;
            busy_r      <= 1'b1;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    ready_r <= 1'b0;
                    busy_r  <= 1'b0;
                end
                ST_CALC: begin
                    acc_r       <= acc_r + partial_s;
                    mcand_sh_r  <= mcand_sh_r << BPC;
                    mplier_sh_r <= mplier_sh_r >> BPC;
                    if (cnt_r == CNT_LAST) begin
                        state_r <= ST_ADJ;
                    end else begin
                        cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
                    end
                end
                ST_ADJ: begin
                    result_r <= adj_s;
                    ready_r  <= 1'b1;
                    busy_r   <= 1'b0;
                    state_r  <= ST_DONE;
                end
                ST_DONE: begin
                    ready_r <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    ready_r <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.result_o = result_r;
    assign bus.ready_o  = ready_r;
    assign bus.busy_o   = busy_r;

endmodule
